// File: rtl/seg7_readback_decoder.sv
// Seven-segment display bus reader: samples the two digit patterns, waits for
// them to stay stable, decodes the pair back to a binary value and reports each
// new displayed value once, flagging illegal patterns and up-count breaks.
module seg7_readback_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int WRAP          = 16,
  parameter int CHECK_SEQ     = 1
) (
  input  logic       clock50M,
  input  logic       reset,
  input  logic [6:0] d1,
  input  logic [6:0] d0,
  output logic [6:0] value,
  output logic       valid,
  output logic       pat_err,
  output logic       seq_err,
  output logic [7:0] capture_count
);

  typedef enum logic [1:0] {SETTLE, REPORT, HOLD} state_t;

  localparam logic [15:0] STAB    = 16'(STABLE_CYCLES);
  localparam logic [15:0] STAB_M1 = 16'(STABLE_CYCLES - 1);

  // Active-low segments, bit0=a .. bit6=g. Result is {legal, digit}.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'b1000000: seg_decode = 5'b1_0000;
      7'b1111001: seg_decode = 5'b1_0001;
      7'b0100100: seg_decode = 5'b1_0010;
      7'b0110000: seg_decode = 5'b1_0011;
      7'b0011001: seg_decode = 5'b1_0100;
      7'b0010010: seg_decode = 5'b1_0101;
      7'b0000010: seg_decode = 5'b1_0110;
      7'b1111000: seg_decode = 5'b1_0111;
      7'b0000000: seg_decode = 5'b1_1000;
      7'b0010000: seg_decode = 5'b1_1001;
      default:    seg_decode = 5'b0_0000;
    endcase
  endfunction

  // Value the up-counter should show after v.
  function automatic logic [6:0] next_in_seq(input logic [6:0] v);
    int t;
    t = (int'(v) + 1) % WRAP;
    return 7'(t);
  endfunction

  logic [13:0] samp;
  logic [13:0] samp_prev;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [13:0] last_pair;
  logic        have_last;
  state_t      state;
  state_t      state_nxt;

  logic        eq;
  logic        do_rep;
  logic        dup;
  logic        legal;
  logic        seq_bad;
  logic [4:0]  dec1;
  logic [4:0]  dec0;
  logic [6:0]  new_val;

  // Sample register, its one-cycle history and the stability counter
  always_ff @(posedge clock50M or negedge reset) begin
    if (!reset) begin
      samp      <= 14'h3FFF;
      samp_prev <= 14'h3FFF;
      cnt       <= 16'd0;
      state     <= SETTLE;
    end else begin
      samp      <= {d1, d0};
      samp_prev <= samp;
      cnt       <= cnt_nxt;
      state     <= state_nxt;
    end
  end

  // Next-state logic; the report decision is taken on the SETTLE->REPORT edge
  // so the registered pulses are high exactly while the FSM sits in REPORT.
  always_comb begin
    state_nxt = state;
    do_rep    = 1'b0;
    eq        = (samp == samp_prev);
    if (!eq)              cnt_nxt = 16'd0;
    else if (cnt >= STAB) cnt_nxt = STAB;
    else                  cnt_nxt = cnt + 16'd1;
    case (state)
      SETTLE: if (eq && cnt_nxt == STAB_M1) begin
        state_nxt = REPORT;
        do_rep    = 1'b1;
      end
      REPORT:  state_nxt = HOLD;
      HOLD:    state_nxt = HOLD;
      default: state_nxt = SETTLE;
    endcase
    if (!eq) state_nxt = SETTLE;
  end

  // Decode of the stable pair and its classification
  always_comb begin
    dec1    = seg_decode(samp[13:7]);
    dec0    = seg_decode(samp[6:0]);
    legal   = dec1[4] & dec0[4];
    new_val = {3'b000, dec1[3:0]} * 7'd10 + {3'b000, dec0[3:0]};
    dup     = have_last && (samp == last_pair);
    seq_bad = (CHECK_SEQ != 0) && have_last && (new_val != next_in_seq(value));
  end

  // Result pulses, decoded value, reference pair and report counter
  always_ff @(posedge clock50M or negedge reset) begin
    if (!reset) begin
      value         <= 7'd0;
      valid         <= 1'b0;
      pat_err       <= 1'b0;
      seq_err       <= 1'b0;
      capture_count <= 8'd0;
      last_pair     <= 14'h3FFF;
      have_last     <= 1'b0;
    end else begin
      valid   <= 1'b0;
      pat_err <= 1'b0;
      seq_err <= 1'b0;
      if (do_rep && !dup) begin
        last_pair <= samp;
        if (legal) begin
          value     <= new_val;
          valid     <= 1'b1;
          seq_err   <= seq_bad;
          have_last <= 1'b1;
          if (capture_count != 8'hFF) capture_count <= capture_count + 8'd1;
        end else begin
          pat_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Bench for seg7_readback_decoder: a table of displayed pairs with hand-written
// expected reports feeds a queue; a monitor pops and checks every pulse.
`timescale 1ns/1ps
module tb_seg7_readback_decoder;
  localparam int S = 4;
  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_PAT   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] d1 = 7'h7F;
  logic [6:0] d0 = 7'h7F;
  logic [6:0] value, ns_value;
  logic       valid, pat_err, seq_err, ns_valid, ns_pat_err, ns_seq_err;
  logic [7:0] capture_count, ns_capture_count;

  seg7_readback_decoder #(.STABLE_CYCLES(S), .WRAP(16), .CHECK_SEQ(1)) dut (
    .clock50M(clk), .reset(reset), .d1(d1), .d0(d0), .value(value),
    .valid(valid), .pat_err(pat_err), .seq_err(seq_err),
    .capture_count(capture_count));

  seg7_readback_decoder #(.STABLE_CYCLES(S), .WRAP(16), .CHECK_SEQ(0)) dut_ns (
    .clock50M(clk), .reset(reset), .d1(d1), .d0(d0), .value(ns_value),
    .valid(ns_valid), .pat_err(ns_pat_err), .seq_err(ns_seq_err),
    .capture_count(ns_capture_count));

  always #10 clk = ~clk;

  typedef struct {
    bit         rst_before;
    logic [6:0] p1;
    logic [6:0] p0;
    int         hold;
    int         kind;
    int         val;
    bit         seq;
  } vec_t;

  typedef struct {
    int edge_no;
    int kind;
    int val;
    bit seq;
    int cnt;
  } exp_t;

  vec_t tab[$];
  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   exp_val = 0;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic vec_t mkp(input bit r, input logic [6:0] p1, input logic [6:0] p0,
                               input int hold, input int kind, input int val, input bit seq);
    vec_t v;
    v.rst_before = r; v.p1 = p1; v.p0 = p0; v.hold = hold;
    v.kind = kind; v.val = val; v.seq = seq;
    return v;
  endfunction

  function automatic vec_t mk(input bit r, input int t, input int u, input int hold,
                              input int kind, input int val, input bit seq);
    return mkp(r, seg(t), seg(u), hold, kind, val, seq);
  endfunction

  // Edge counter and pulse monitor, sampled 1ns after each rising edge
  always begin
    @(posedge clk);
    if (!reset) cyc = 0;
    else cyc++;
    #1;
    if (reset && q.size() > 0 && q[0].edge_no < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL missed_report: nothing seen at edge %0d, required kind=%0d value=%0d",
               q[0].edge_no, q[0].kind, q[0].val);
      void'(q.pop_front());
    end
    if (valid | pat_err | seq_err | ns_valid | ns_pat_err | ns_seq_err) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pulse edge=%0d valid=%b pat=%b seq=%b ns_valid=%b ns_pat=%b ns_seq=%b, required none",
                 cyc, valid, pat_err, seq_err, ns_valid, ns_pat_err, ns_seq_err);
      end else begin
        e = q.pop_front();
        n_cmp++;
        if (cyc != e.edge_no || valid != (e.kind == K_VALID) || pat_err != (e.kind == K_PAT) ||
            seq_err != e.seq || int'(value) != e.val || int'(capture_count) != e.cnt) begin
          n_bad++;
          $display("FAIL report: got edge=%0d valid=%b pat=%b seq=%b value=%0d count=%0d, required edge=%0d valid=%b pat=%b seq=%b value=%0d count=%0d",
                   cyc, valid, pat_err, seq_err, value, capture_count, e.edge_no,
                   e.kind == K_VALID, e.kind == K_PAT, e.seq, e.val, e.cnt);
        end
        n_cmp++;
        if (cyc != e.edge_no || ns_valid != (e.kind == K_VALID) || ns_pat_err != (e.kind == K_PAT) ||
            ns_seq_err != 1'b0 || int'(ns_value) != e.val || int'(ns_capture_count) != e.cnt) begin
          n_bad++;
          $display("FAIL report_noseq: got edge=%0d valid=%b pat=%b seq=%b value=%0d count=%0d, required edge=%0d valid=%b pat=%b seq=0 value=%0d count=%0d",
                   cyc, ns_valid, ns_pat_err, ns_seq_err, ns_value, ns_capture_count, e.edge_no,
                   e.kind == K_VALID, e.kind == K_PAT, e.val, e.cnt);
        end
      end
    end
  end

  // Drive one table entry; called at a falling edge
  task automatic apply(input vec_t v);
    int   start;
    exp_t x;
    if (v.rst_before) begin
      reset = 1'b0;
      d1 = v.p1;
      d0 = v.p0;
      #1;
      n_cmp++;
      if (value != 0 || valid || pat_err || seq_err || capture_count != 0 ||
          ns_value != 0 || ns_valid || ns_pat_err || ns_seq_err || ns_capture_count != 0) begin
        n_bad++;
        $display("FAIL reset_state: value=%0d valid=%b pat=%b seq=%b count=%0d ns_value=%0d ns_count=%0d, required all 0",
                 value, valid, pat_err, seq_err, capture_count, ns_value, ns_capture_count);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      // A still-blank bus after reset matches the reset sample, so its
      // stability window is already running; anything else is sampled at edge 1.
      start = ({v.p1, v.p0} == 14'h3FFF) ? -1 : 1;
      exp_cnt = 0;
      exp_val = 0;
    end else begin
      d1 = v.p1;
      d0 = v.p0;
      start = cyc + 1;
    end
    if (v.kind != K_NONE) begin
      if (v.kind == K_VALID) begin
        if (exp_cnt < 255) exp_cnt++;
        exp_val = v.val;
      end
      x.edge_no = start + S;
      x.kind = v.kind;
      x.val = exp_val;
      x.seq = v.seq;
      x.cnt = exp_cnt;
      q.push_back(x);
    end
    repeat (v.hold) @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b0;
    // blank bus through reset, then "01" from edge 10
    tab.push_back(mkp(1, 7'h7F, 7'h7F, 9, K_PAT, 0, 0));
    tab.push_back(mk(0, 0, 1, 8, K_VALID, 1, 0));
    // full count 0..15, wrap, on to 3
    tab.push_back(mk(1, 0, 0, 8, K_VALID, 0, 0));
    for (int i = 1; i < 16; i++) tab.push_back(mk(0, i / 10, i % 10, 8, K_VALID, i, 0));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0, 0, i, 8, K_VALID, i, 0));
    // glitch to 08 and back to 03, then 04
    tab.push_back(mk(0, 0, 8, 2, K_NONE, 0, 0));
    tab.push_back(mk(0, 0, 3, 8, K_NONE, 0, 0));
    tab.push_back(mk(0, 0, 4, 8, K_VALID, 4, 0));
    // sequence breaks
    tab.push_back(mk(0, 0, 5, 8, K_VALID, 5, 0));
    tab.push_back(mk(0, 0, 7, 8, K_VALID, 7, 1));
    tab.push_back(mk(0, 0, 6, 8, K_VALID, 6, 1));
    // illegal units pattern keeps value 6 as the sequence reference
    tab.push_back(mkp(0, seg(0), 7'b1010101, 8, K_PAT, 0, 0));
    tab.push_back(mk(0, 0, 7, 8, K_VALID, 7, 0));
    // values past WRAP-1
    tab.push_back(mk(0, 1, 5, 8, K_VALID, 15, 1));
    tab.push_back(mk(0, 1, 6, 8, K_VALID, 16, 1));
    tab.push_back(mk(0, 0, 1, 8, K_VALID, 1, 0));
    // reset two cycles into a new pattern aborts it; reported fresh afterwards
    tab.push_back(mk(0, 0, 9, 2, K_NONE, 0, 0));
    tab.push_back(mk(1, 0, 9, 8, K_VALID, 9, 0));
    tab.push_back(mk(0, 1, 0, 8, K_VALID, 10, 0));
    // held exactly S cycles is reported, S-1 cycles is not
    tab.push_back(mk(0, 1, 1, S, K_VALID, 11, 0));
    tab.push_back(mk(0, 1, 2, S - 1, K_NONE, 0, 0));
    tab.push_back(mk(0, 1, 3, 8, K_VALID, 13, 1));

    @(negedge clk);
    foreach (tab[i]) apply(tab[i]);
    repeat (S + 4) @(negedge clk);
    while (q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover_report: edge %0d kind=%0d value=%0d never seen", q[0].edge_no, q[0].kind, q[0].val);
      void'(q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
